pc_update_unit: RTL
===================

# pc_update_unit

Program-counter stage of the single-cycle datapath. It holds the architectural PC and the Z/V/N condition flags, and selects the next PC from three sources: sequential, branch target, or register jump. The branch target arrives from the branch-target calculator in EX. It also sequences halt and instruction-memory stalls, and keeps a retired-instruction counter.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- instr  in  16  instruction currently at `pc`; [15:12] opcode, [11:9] condition code.
- br_pc  in  16  branch target from the branch calculator (pc+1+offset). Valid only when opcode==4'b1100; X otherwise.
- jr_pc  in  16  register-sourced jump target from the register file.
- alu_flags  in  3  {Z,V,N} produced by the current instruction.
- flag_we  in  1  current instruction writes the flags.
- imem_rdy  in  1  instruction memory has valid data at `pc`.
- pc  out  16  current PC (registered).
- pc_plus1  out  16  pc+1, mod 2^16.
- br_taken  out  1  current instruction redirects the PC (branch taken or JR).
- halted  out  1  core is in HALT.
- retired  out  16  count of retired instructions, saturating.

## Operation
- Opcodes: 1100 B (conditional, target br_pc); 1110 JR (target jr_pc); 1111 HLT; all others are sequential.
- Conditions use the registered flags, never alu_flags:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: Z=1 or N=1.
  - 110 OVFL: V=1.
  - 111 always.
- next_pc:
  - B and condition true: br_pc.
  - JR: jr_pc.
  - Otherwise: pc_plus1.
  - br_pc must not reach next_pc, br_taken, or any register unless opcode==1100. No X propagation from br_pc.
- FSM states:
  - RUN: if imem_rdy=0, hold everything (stall). If imem_rdy=1 and opcode==HLT, go to HALT; pc is not advanced. Otherwise retire: pc<=next_pc, retired++, flags<=alu_flags if flag_we.
  - HALT: terminal. pc, flags and retired are frozen. Only rst leaves HALT.
- Retirement = a RUN cycle with imem_rdy=1 and a non-HLT opcode. HLT itself is not counted.
- retired saturates at 16'hFFFF.
- A stalled cycle has no side effects: flags are not written even if flag_we=1.
- br_taken is combinational. It is gated by imem_rdy and by state RUN, so it is 0 during stall and in HALT.
- Arithmetic: all PC values are 16-bit modulo. pc=16'hFFFF sequential gives 16'h0000; this is not an error.

## Timing
- Reset, synchronous: on a rst=1 edge pc<=RESET_PC, flags<=3'b000, retired<=0, state<=RUN. Hence halted=0 and pc_plus1=RESET_PC+1.
- rst wins over every simultaneous event: stall, HLT, branch, or already in HALT.
- Latency: next_pc is combinational within the cycle. pc updates on the following edge, giving one instruction per cycle when imem_rdy=1.
- Flag hazard: a branch in the same cycle as flag_we sees the old flags. The new flags become visible to the next instruction.
- HLT with imem_rdy=0: stall; HALT is not entered until imem_rdy=1.
- halted rises on the edge after an accepted HLT and stays high until reset.

## Structure
- Shared package `isa_pkg`:
  - opcode localparams (B, JR, HLT).
  - condition-code localparams.
  - flag bit indices Z=2, V=1, N=0.
  - FSM state encoding (RUN, HALT).
- Sub-module `br_cond_eval`: combinational; inputs ccc[2:0] and flags[2:0], output cond_true.
- Remaining logic, in the top: next-PC mux, FSM, and the flag, PC and counter registers.

## Test plan
- Reset/sequential: rst for 1 cycle, then nop opcode 0000 with imem_rdy=1 for 3 cycles -> pc 0000, 0001, 0002, 0003; retired=3; halted=0.
- Branch taken/not taken:
  - Setup: flags written Z=1 (flag_we=1) at pc=0005; next cycle B with ccc=001, br_pc=0010.
  - Required: pc=0010, br_taken=1.
  - Same setup with ccc=000: pc=0007, br_taken=0.
- X isolation and wrap: br_pc driven 16'hxxxx with opcode 0000 at pc=FFFF -> next pc=0000, br_taken=0, no X on any output.
- Stall and flag gating: JR with jr_pc=1234 while imem_rdy=0 for 2 cycles, flag_we=1 -> pc, flags and retired unchanged, br_taken=0. Then imem_rdy=1 -> pc=1234.
- Halt:
  - HLT at pc=0020 -> halted=1 the next cycle; pc stays 0020 for 5 further cycles with arbitrary instr; retired unchanged.
  - Then rst=1 -> pc=RESET_PC, halted=0.
- Counter saturation: force 65536+ retirements -> retired holds FFFF.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the PC stage: opcodes, condition codes,
// flag bit positions and the PC-stage FSM state encoding.
package isa_pkg;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_JR  = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] CC_NE   = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GTE  = 3'b100;
    localparam logic [2:0] CC_LTE  = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;
    localparam logic [2:0] CC_AL   = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: decides whether a condition code holds
// for a given {Z,V,N} flag set. Purely combinational.
module br_cond_eval
    import isa_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic flag_z;
    logic flag_v;
    logic flag_n;

    assign flag_z = flags[FLAG_Z];
    assign flag_v = flags[FLAG_V];
    assign flag_n = flags[FLAG_N];

    // Map each condition code onto its flag expression
    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            CC_NE:   cond_true = ~flag_z;
            CC_EQ:   cond_true = flag_z;
            CC_GT:   cond_true = ~flag_z & ~flag_n;
            CC_LT:   cond_true = flag_n;
            CC_GTE:  cond_true = flag_z | ~flag_n;
            CC_LTE:  cond_true = flag_z | flag_n;
            CC_OVFL: cond_true = flag_v;
            CC_AL:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter stage: holds PC, condition flags and the retired
// counter, selects the next PC and sequences stall and halt.
module pc_update_unit
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] br_pc,
    input  logic [15:0] jr_pc,
    input  logic [2:0]  alu_flags,
    input  logic        flag_we,
    input  logic        imem_rdy,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        br_taken,
    output logic        halted,
    output logic [15:0] retired
);

    pc_state_t   state_q;
    pc_state_t   state_d;
    logic [2:0]  flags_q;
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic [8:0]  unused_operand;
    logic        is_b;
    logic        is_jr;
    logic        is_hlt;
    logic        cond_true;
    logic        branch_hit;
    logic        active;
    logic        retire;
    logic [15:0] next_pc;

    assign opcode         = instr[15:12];
    assign ccc            = instr[11:9];
    assign unused_operand = instr[8:0];

    assign is_b   = (opcode == OP_B);
    assign is_jr  = (opcode == OP_JR);
    assign is_hlt = (opcode == OP_HLT);

    br_cond_eval u_cond (
        .ccc       (ccc),
        .flags     (flags_q),
        .cond_true (cond_true)
    );

    assign pc_plus1   = pc + 16'd1;
    assign branch_hit = is_b & cond_true;
    assign active     = (state_q == ST_RUN) & imem_rdy;
    assign retire     = active & ~is_hlt;
    assign br_taken   = active & (branch_hit | is_jr);
    assign halted     = (state_q == ST_HALT);

    // Next-PC select; br_pc is only ever looked at when the opcode is B
    always_comb begin
        next_pc = pc_plus1;
        if (branch_hit) begin
            next_pc = br_pc;
        end else if (is_jr) begin
            next_pc = jr_pc;
        end
    end

    // FSM next state: an accepted HLT parks the core until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (active && is_hlt) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Architectural state only moves on a retiring cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            flags_q <= 3'b000;
            retired <= 16'h0000;
        end else if (retire) begin
            pc <= next_pc;
            if (flag_we) begin
                flags_q <= alu_flags;
            end
            if (retired != 16'hFFFF) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule
